ask_decim_slicer: RTL and testbench
===================================

// Module: ask_decim_slicer
// PURPOSE
//  Downstream of the GSM_101Mults pulse-shaping/matched filter. Consumes filter output y at the sample rate,
//  decimates to one sample per symbol at a selectable phase, and slices it into 4-ASK symbols.
//  The decision threshold adapts from a block average of |y|. Also reports slicer error for eye/MER measurement.
// PARAMETERS
//  WIDTH     18    sample width, signed
//  SPS       4     samples per symbol (sam_clk_en pulses per sym_clk_en)
//  AVG_LOG2  10    log2 of symbols per reference-averaging block (1024)
//  REF_INIT  18'sd32768  ref_level value after reset
// PORTS
//  sys_clk     in   1      system clock
//  reset       in   1      asynchronous, active-high
//  sam_clk_en  in   1      one-sys_clk sample strobe
//  sym_clk_en  in   1      one-sys_clk symbol strobe; always coincides with a sam_clk_en pulse
//  phase_sel   in   2      decimation phase 0..SPS-1
//  y_in        in   WIDTH  signed filter output
//  sym_out     out  2      Gray symbol: 00=-3d, 01=-d, 11=+d, 10=+3d
//  sym_valid   out  1      one-sys_clk pulse, sym_out/err_out new
//  err_out     out  WIDTH  signed y - ideal level, saturated
//  ref_level   out  WIDTH  current threshold = mean|y| (equals 2d)
//  ref_update  out  1      one-sys_clk pulse when ref_level reloads
//  mse_out     out  2*WIDTH  block sum of err^2 >> AVG_LOG2 (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: sym_out=0, sym_valid=0, err_out=0, ref_level=REF_INIT, ref_update=0, mse_out=0.
//    Phase counter, symbol counter, and accumulators are cleared.
//  - Phase counter: on sam_clk_en&&sym_clk_en it loads 0; on any other sam_clk_en it increments mod SPS.
//    The cycle is a "take" cycle when sam_clk_en && (phase_next == phase_sel).
//    phase_next is the value the counter holds after this strobe.
//  - phase_sel changes take effect at the next strobe. phase_sel >= SPS never takes.
//  - Take -> registered outputs on next sys_clk edge: latency 1 sys_clk; sym_valid high exactly 1 cycle.
//  - Slicer, using ref_level before this take's update (T = ref_level, d = T>>>1):
//    y >= T -> 10; 0 <= y < T -> 11; -T <= y < 0 -> 01; y < -T -> 00.
//  - Ideal levels are +-d and +-3d, where 3d = d + (d<<1).
//    err = y - ideal, computed at WIDTH+2 bits and saturated to WIDTH.
//  - |y|: -2^(WIDTH-1) maps to 2^(WIDTH-1)-1.
//  - Averaging: acc (WIDTH+AVG_LOG2 bits) adds |y| on each take. Symbol counter counts takes.
//    On the 2^AVG_LOG2-th take: ref_level <= (acc+|y|)>>AVG_LOG2, ref_update pulses with sym_valid,
//    acc restarts at 0, and the counter wraps to 0. No sample is lost at the wrap.
//  - ref_level is never 0: a computed value of 0 loads 1.
//  - Reset mid-block: everything returns to reset values; the partial block is discarded.
//  - No take while sam_clk_en=0, regardless of sym_clk_en.
// CONFIGURATION
//  ERR_SQ_ACC_EN defined:
//    err_out^2 is accumulated per take in a 2*WIDTH+AVG_LOG2 saturating accumulator.
//    At each block wrap, mse_out <= sum>>AVG_LOG2, updated on the same cycle as ref_update.
//  ERR_SQ_ACC_EN undefined: the multiplier and accumulator are absent; mse_out is constant 0.
// TESTING
//  1. Reset: assert reset async mid-cycle -> all outputs at reset values immediately; ref_level=32768.
//  2. Decimation: SPS=4, phase_sel=2, y_in=sample index -> sym_valid every 4th sam_clk_en.
//     The taken y is the one at phase 2; sym_valid occurs 1 sys_clk after the strobe.
//  3. Slicing, T=32768: y = 40000, 20000, -20000, -40000 -> sym 10, 11, 01, 00.
//     err = 40000-49152 = -9152, 20000-16384 = 3616, -3616, 9152.
//  4. Ref tracking: AVG_LOG2=4, 16 takes of |y|=24000 -> ref_update on the 16th sym_valid.
//     ref_level=24000 after it; the 17th symbol is sliced against 24000.
//  5. Saturation: y=-131072, T=1 -> sym 00, |y| accumulates 131071, err saturates to -131072.
//  6. ERR_SQ_ACC_EN, AVG_LOG2=4: constant err=100 -> mse_out=10000 at the wrap; without the macro, mse_out stays 0.

Source files
------------

// File: rtl/ask_decim_slicer.sv
// ask_decim_slicer
//   Decimates matched-filter output to one sample per symbol at a selectable
//   phase and slices it into Gray-coded 4-ASK symbols. The decision threshold
//   is the block mean of |y|, reloaded every 2^AVG_LOG2 symbols. The slicer
//   error is reported for eye/MER measurement.
//
//   Optional feature macro: ERR_SQ_ACC_EN. When defined, the squared slicer
//   error is accumulated per block and mse_out reports the block mean. When
//   undefined, mse_out is constant 0.
//
// Ports
//   sys_clk     in   1        system clock
//   reset       in   1        asynchronous, active-high
//   sam_clk_en  in   1        sample strobe
//   sym_clk_en  in   1        symbol strobe (coincides with a sample strobe)
//   phase_sel   in   2        decimation phase 0..SPS-1
//   y_in        in   WIDTH    signed filter output
//   sym_out     out  2        Gray symbol: 00=-3d 01=-d 11=+d 10=+3d
//   sym_valid   out  1        one-cycle pulse, sym_out/err_out new
//   err_out     out  WIDTH    saturated y - ideal level
//   ref_level   out  WIDTH    threshold T = mean|y| (= 2d)
//   ref_update  out  1        one-cycle pulse when ref_level reloads
//   mse_out     out  2*WIDTH  block mean of err^2
module ask_decim_slicer #(
  parameter int                       WIDTH    = 18,
  parameter int                       SPS      = 4,
  parameter int                       AVG_LOG2 = 10,
  parameter logic signed [WIDTH-1:0]  REF_INIT = 18'sd32768
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     sam_clk_en,
  input  logic                     sym_clk_en,
  input  logic [1:0]               phase_sel,
  input  logic signed [WIDTH-1:0]  y_in,
  output logic [1:0]               sym_out,
  output logic                     sym_valid,
  output logic signed [WIDTH-1:0]  err_out,
  output logic signed [WIDTH-1:0]  ref_level,
  output logic                     ref_update,
  output logic [2*WIDTH-1:0]       mse_out
);

  localparam int PH_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int CW   = (PH_W > 2) ? PH_W : 2;
  localparam int AW   = WIDTH + AVG_LOG2;

  function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
    if (v == $signed({1'b1, {(WIDTH-1){1'b0}}}))
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < 0)
      return WIDTH'(-v);
    else
      return WIDTH'(v);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [WIDTH+1:0] v);
    if (v > $signed({3'b000, {(WIDTH-1){1'b1}}}))
      return {1'b0, {(WIDTH-1){1'b1}}};
    else if (v < $signed({3'b111, {(WIDTH-1){1'b0}}}))
      return {1'b1, {(WIDTH-1){1'b0}}};
    else
      return v[WIDTH-1:0];
  endfunction

  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    take;
  logic [AVG_LOG2-1:0]     cnt_q;
  logic                    wrap;
  logic [AW-1:0]           acc_q, acc_sum;
  logic [WIDTH-1:0]        abs_y;
  logic signed [WIDTH-1:0] ref_q, ref_calc;
  logic [1:0]              sym_q, sym_c;
  logic signed [WIDTH-1:0] err_q, err_c;
  logic                    vld_q, upd_q;
  logic signed [WIDTH+1:0] y_x, t_x, d_x, d3_x, ideal_x, err_x;

  // Phase counter: symbol strobe realigns to 0, other strobes advance mod SPS.
  always_comb begin
    phase_d = phase_q;
    if (sam_clk_en) begin
      if (sym_clk_en || (phase_q == PH_W'(SPS - 1)))
        phase_d = '0;
      else
        phase_d = phase_q + 1'b1;
    end
  end

  // phase_sel values beyond SPS-1 never match a counter value, so never take.
  assign take = sam_clk_en && (CW'(phase_d) == CW'(phase_sel));
  assign wrap = &cnt_q;

  // Slicer against the threshold in force before this take's update.
  always_comb begin
    y_x  = {{2{y_in[WIDTH-1]}}, y_in};
    t_x  = {{2{ref_q[WIDTH-1]}}, ref_q};
    d_x  = t_x >>> 1;
    d3_x = d_x + (d_x <<< 1);
    if (y_x >= t_x) begin
      sym_c   = 2'b10;
      ideal_x = d3_x;
    end else if (y_x >= 0) begin
      sym_c   = 2'b11;
      ideal_x = d_x;
    end else if (y_x >= -t_x) begin
      sym_c   = 2'b01;
      ideal_x = -d_x;
    end else begin
      sym_c   = 2'b00;
      ideal_x = -d3_x;
    end
    err_x = y_x - ideal_x;
    err_c = sat_w(err_x);
  end

  // Block mean of |y|; the closing sample is folded in before the divide.
  always_comb begin
    abs_y    = abs_sat(y_in);
    acc_sum  = acc_q + AW'(abs_y);
    ref_calc = $signed(WIDTH'(acc_sum >> AVG_LOG2));
    if (ref_calc == '0)
      ref_calc = {{(WIDTH-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ref_q   <= REF_INIT;
      sym_q   <= '0;
      err_q   <= '0;
      vld_q   <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vld_q   <= take;
      upd_q   <= take && wrap;
      if (take) begin
        sym_q <= sym_c;
        err_q <= err_c;
        cnt_q <= cnt_q + 1'b1;
        if (wrap) begin
          acc_q <= '0;
          ref_q <= ref_calc;
        end else begin
          acc_q <= acc_sum;
        end
      end
    end
  end

`ifdef ERR_SQ_ACC_EN
  localparam int SW = 2*WIDTH + AVG_LOG2;

  logic signed [2*WIDTH-1:0] err_sq;
  logic [SW:0]               sq_sum;
  logic [SW-1:0]             sq_q, sq_next;
  logic [2*WIDTH-1:0]        mse_q;

  // One guard bit above the accumulator detects overflow for saturation.
  always_comb begin
    err_sq  = err_c * err_c;
    sq_sum  = {1'b0, sq_q} + (SW+1)'($unsigned(err_sq));
    sq_next = sq_sum[SW] ? {SW{1'b1}} : sq_sum[SW-1:0];
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sq_q  <= '0;
      mse_q <= '0;
    end else if (take) begin
      if (wrap) begin
        sq_q  <= '0;
        mse_q <= (2*WIDTH)'(sq_next >> AVG_LOG2);
      end else begin
        sq_q  <= sq_next;
      end
    end
  end

  assign mse_out = mse_q;
`else
  assign mse_out = '0;
`endif

  assign sym_out    = sym_q;
  assign sym_valid  = vld_q;
  assign err_out    = err_q;
  assign ref_level  = ref_q;
  assign ref_update = upd_q;

endmodule

// File: tb/tb_ask_decim_slicer.sv
// Self-checking bench for ask_decim_slicer (SPS=4, AVG_LOG2=4 so blocks are
// 16 symbols). A behavioural model computes expected outputs from the
// slicing/averaging rules with plain integer arithmetic.
module tb_ask_decim_slicer;
  localparam int W   = 18;
  localparam int SPS = 4;
  localparam int AL  = 4;
  localparam int BLK = 1 << AL;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sam, sym;
  logic [1:0]           psel;
  logic signed [W-1:0]  y;
  logic [1:0]           sym_out;
  logic                 sym_valid;
  logic signed [W-1:0]  err_out;
  logic signed [W-1:0]  ref_level;
  logic                 ref_update;
  logic [2*W-1:0]       mse_out;

  always #5 clk = ~clk;

  ask_decim_slicer #(
    .WIDTH(W), .SPS(SPS), .AVG_LOG2(AL), .REF_INIT(18'sd32768)
  ) dut (
    .sys_clk(clk), .reset(reset), .sam_clk_en(sam), .sym_clk_en(sym),
    .phase_sel(psel), .y_in(y), .sym_out(sym_out), .sym_valid(sym_valid),
    .err_out(err_out), .ref_level(ref_level), .ref_update(ref_update),
    .mse_out(mse_out)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model state and expected outputs
  int     m_ph, m_cnt, e_sym;
  longint m_ref, m_acc, m_sq, m_mse, e_err;
  bit     e_vld, e_upd;

  // Values captured on the cycle after a take inside sym_blk
  logic                o_vld, o_upd;
  logic [1:0]          o_sym;
  logic signed [W-1:0] o_err;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("sym_valid", sym_valid, e_vld);
    chk("ref_update", ref_update, e_upd);
    chk("sym_out", sym_out, e_sym);
    chk("err_out", err_out, e_err);
    chk("ref_level", ref_level, m_ref);
    chk("mse_out", mse_out, m_mse);
  endtask

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; e_sym = 0;
    m_ref = 32768; m_acc = 0; m_sq = 0; m_mse = 0; e_err = 0;
    e_vld = 0; e_upd = 0;
  endtask

  task automatic step(input bit s_sam, input bit s_sym, input logic [1:0] s_ps,
                      input int s_y);
    bit     take;
    longint t, d, ideal, e, a;
    sam = s_sam; sym = s_sym; psel = s_ps; y = W'(s_y);
    take = 0;
    if (s_sam) begin
      m_ph = s_sym ? 0 : (m_ph + 1) % SPS;
      take = (m_ph == int'(s_ps));
    end
    e_vld = take;
    e_upd = 0;
    if (take) begin
      t = m_ref;
      d = t / 2;
      if (s_y >= t)       begin e_sym = 2; ideal = 3 * d;  end
      else if (s_y >= 0)  begin e_sym = 3; ideal = d;      end
      else if (s_y >= -t) begin e_sym = 1; ideal = -d;     end
      else                begin e_sym = 0; ideal = -3 * d; end
      e = s_y - ideal;
      if (e > 131071)  e = 131071;
      if (e < -131072) e = -131072;
      e_err = e;
      a = (s_y < 0) ? -longint'(s_y) : longint'(s_y);
      if (a > 131071) a = 131071;
      m_acc += a;
      m_sq  += e * e;
      if (m_sq > (longint'(1) << (2*W + AL)) - 1) m_sq = (longint'(1) << (2*W + AL)) - 1;
      m_cnt++;
      if (m_cnt == BLK) begin
        m_ref = m_acc / BLK;
        if (m_ref == 0) m_ref = 1;
`ifdef ERR_SQ_ACC_EN
        m_mse = m_sq / BLK;
`endif
        m_acc = 0; m_sq = 0; m_cnt = 0;
        e_upd = 1;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One symbol period with a constant sample value.
  task automatic sym_blk(input logic [1:0] ps, input int yv);
    for (int j = 0; j < SPS; j++) begin
      step(1'b1, j == 0, ps, yv);
      if (j == int'(ps)) begin
        o_vld = sym_valid; o_upd = ref_update; o_sym = sym_out; o_err = err_out;
      end
    end
  endtask

  // Asserts reset between clock edges and checks outputs before the next edge.
  task automatic do_async_reset();
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all();
  endtask

  initial begin
    int sy [4];
    int se [4];
    int k;
    bit rs, rsm;
    logic [1:0] rp;
    int ry;

    reset = 1'b1; sam = 0; sym = 0; psel = 0; y = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    // Decimation at phase 2 with y = sample index
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i % SPS) == 0, 2'd2, i);
      if ((i % SPS) == 2) chk("dec_take", sym_valid, 1);
    end
    step(1'b0, 1'b1, 2'd2, 99);
    chk("no_take_without_sam", sym_valid, 0);

    // Mid-block asynchronous reset
    do_async_reset();
    chk("rst_ref", ref_level, 32768);
    chk("rst_err", err_out, 0);

    // Slicing at T=32768
    sy = '{40000, 20000, -20000, -40000};
    se = '{-9152, 3616, -3616, 9152};
    for (int i = 0; i < 4; i++) begin
      sym_blk(2'd0, sy[i]);
      chk("slice_vld", o_vld, 1);
      chk("slice_sym", o_sym, (i == 0) ? 2 : (i == 1) ? 3 : (i == 2) ? 1 : 0);
      chk("slice_err", o_err, se[i]);
    end

    // Reference tracking
    do_async_reset();
    for (int i = 0; i < BLK; i++) begin
      sym_blk(2'd1, (i % 2) ? -24000 : 24000);
      chk("trk_upd", o_upd, (i == BLK - 1) ? 1 : 0);
    end
    chk("trk_ref", ref_level, 24000);
    sym_blk(2'd1, 24000);
    chk("trk17_sym", o_sym, 2);
    chk("trk17_err", o_err, -12000);

    // Zero block gives T=1, then most-negative input
    do_async_reset();
    for (int i = 0; i < BLK; i++) sym_blk(2'd0, 0);
    chk("ref_floor", ref_level, 1);
    sym_blk(2'd0, -131072);
    chk("sat_sym", o_sym, 0);
    chk("sat_err", o_err, -131072);
    for (int i = 0; i < BLK - 1; i++) sym_blk(2'd0, 0);
    chk("abs_sat_ref", ref_level, 8191);

    // Constant error of 100
    do_async_reset();
    for (int i = 0; i < BLK; i++) begin
      sym_blk(2'd3, 16484);
      chk("err100", o_err, 100);
    end
`ifdef ERR_SQ_ACC_EN
    chk("mse_block", mse_out, 10000);
`else
    chk("mse_block", mse_out, 0);
`endif
    chk("mse_ref", ref_level, 16484);

    // Randomized traffic
    do_async_reset();
    k = 0;
    rp = 2'(($urandom % 4));
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_async_reset();
      rs  = ($urandom % 4) != 0;
      rsm = rs ? ((k % SPS) == 0) : (($urandom % 8) == 0);
      if (rs) k++;
      if (($urandom % 64) == 0) rp = 2'(($urandom % 4));
      case ($urandom % 4)
        0:       ry = int'($urandom_range(0, 262143)) - 131072;
        1:       ry = int'($urandom_range(0, 4000)) - 2000;
        2:       ry = ($urandom % 2) ? -131072 : 131071;
        default: ry = int'($urandom_range(0, 120000)) - 60000;
      endcase
      step(rs, rsm, rp, ry);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
